// File: rtl/bitrev_buffer_pkg.sv
// Shared FFT definitions: default frame geometry, bank-state encoding and the
// bit-reversal helper used to address the reorder buffer.
package bitrev_buffer_pkg;

    localparam int unsigned LOG2N_DEFAULT      = 4;
    localparam int unsigned IN_WIDTH_DEFAULT   = 16;
    localparam int unsigned DATA_WIDTH_DEFAULT = 21;
    localparam int unsigned MAX_LOG2N          = 16;

    typedef enum logic {
        BankFill  = 1'b0,
        BankDrain = 1'b1
    } bank_state_e;

    // Reverses the low 'bits' bits of value; bits above that come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                    input int unsigned bits);
        logic [MAX_LOG2N-1:0] v;
        logic [MAX_LOG2N-1:0] r;
        v = value;
        r = '0;
        for (int unsigned j = 0; j < MAX_LOG2N; j++) begin
            if (j < bits) begin
                r = {r[MAX_LOG2N-2:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Sample bank: one write port and one registered read port. The read register
// holds its value while re_i is low so a stalled output stays stable.
module fft_sample_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 42
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is cleared; memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_buffer.sv
// Natural-order to bit-reversed-order frame buffer feeding the FFT butterflies.
// Define BITREV_BUFFER_PINGPONG_EN for two banks (fill one while draining the other).
module bitrev_buffer
    import bitrev_buffer_pkg::*;
#(
    parameter int unsigned LOG2N      = LOG2N_DEFAULT,
    parameter int unsigned IN_WIDTH   = IN_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [IN_WIDTH-1:0]   in_re_i,
    input  logic signed [IN_WIDTH-1:0]   in_im_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH-1:0] out_re_o,
    output logic signed [DATA_WIDTH-1:0] out_im_o,
    output logic [LOG2N-1:0]             out_idx_o,
    output logic                         out_last_o
);

`ifdef BITREV_BUFFER_PINGPONG_EN
    localparam int unsigned NUM_BANKS = 2;
`else
    localparam int unsigned NUM_BANKS = 1;
`endif

    localparam int unsigned     RAM_W    = 2 * DATA_WIDTH;
    localparam logic [LOG2N-1:0] LAST_IDX = '1;
    localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

    bank_state_e bank_st_q [NUM_BANKS];

    logic [LOG2N-1:0] wr_cnt_q;
    logic             wr_bank_q;
    logic [LOG2N-1:0] nxt_idx_q;
    logic             nxt_bank_q;
    logic             out_bank_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [LOG2N-1:0] out_idx_q;

    logic             in_fire;
    logic             wr_done;
    logic             out_fire;
    logic             last_fire;
    logic             slot_free;
    logic             src_ready;
    logic             load;
    logic [LOG2N-1:0] rd_addr;
    logic [RAM_W-1:0] wdata;
    logic [RAM_W-1:0] rdata [NUM_BANKS];

    assign in_ready_o = (bank_st_q[wr_bank_q] == BankFill);
    assign in_fire    = in_valid_i && in_ready_o;
    assign wr_done    = in_fire && (wr_cnt_q == LAST_IDX);
    assign out_fire   = out_valid_q && out_ready_i;
    assign last_fire  = out_fire && out_last_q;
    assign slot_free  = !out_valid_q || out_ready_i;

    // A draining bank whose own last sample still sits in the output register has
    // nothing left to present; the bank completing its fill this cycle is ready now.
    always_comb begin
        src_ready = 1'b0;
        if (bank_st_q[nxt_bank_q] == BankDrain) begin
            src_ready = !(out_valid_q && (out_bank_q == nxt_bank_q) && (nxt_idx_q == '0));
        end
        if (wr_done && (wr_bank_q == nxt_bank_q)) begin
            src_ready = 1'b1;
        end
    end

    assign load    = slot_free && src_ready;
    assign rd_addr = LOG2N'(bitrev(MAX_LOG2N'(nxt_idx_q), LOG2N));
    assign wdata   = {DATA_WIDTH'(in_re_i), DATA_WIDTH'(in_im_i)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_st_q[b] <= BankFill;
            end
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            nxt_idx_q   <= '0;
            nxt_bank_q  <= 1'b0;
            out_bank_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            if (in_fire) begin
                wr_cnt_q <= wr_cnt_q + IDX_ONE;
                if (wr_done) begin
                    wr_bank_q <= (NUM_BANKS == 2) ? ~wr_bank_q : 1'b0;
                end
            end

            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_done && (wr_bank_q == 1'(b))) begin
                    bank_st_q[b] <= BankDrain;
                end else if (last_fire && (out_bank_q == 1'(b))) begin
                    bank_st_q[b] <= BankFill;
                end
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= nxt_idx_q;
                out_last_q  <= (nxt_idx_q == LAST_IDX);
                out_bank_q  <= nxt_bank_q;
                nxt_idx_q   <= nxt_idx_q + IDX_ONE;
                if (nxt_idx_q == LAST_IDX) begin
                    nxt_bank_q <= (NUM_BANKS == 2) ? ~nxt_bank_q : 1'b0;
                end
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        fft_sample_ram #(
            .ADDR_W (LOG2N),
            .WIDTH  (RAM_W)
        ) u_ram (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (in_fire && (wr_bank_q == 1'(b))),
            .waddr_i (wr_cnt_q),
            .wdata_i (wdata),
            .re_i    (load && (nxt_bank_q == 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (rdata[b])
        );
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_idx_o   = out_idx_q;
    assign out_re_o    = rdata[out_bank_q][RAM_W-1:DATA_WIDTH];
    assign out_im_o    = rdata[out_bank_q][DATA_WIDTH-1:0];

endmodule

// File: doc/bitrev_buffer.md
BITREV_BUFFER -- requirements
Module: bitrev_buffer

Interface
REQ-001 Parameter LOG2N, default 4: log2 of FFT length N; N = 2**LOG2N points per frame.
REQ-002 Parameter IN_WIDTH, default 16: signed input sample width (Q1.15).
REQ-003 Parameter DATA_WIDTH, default 21: signed output width fed to the butterfly stages (5 growth bits).
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 in_valid_i  input  1  input sample present.
REQ-007 in_ready_o  output  1  buffer accepts a sample this cycle.
REQ-008 in_re_i, in_im_i  input  IN_WIDTH each  signed sample, natural order.
REQ-009 out_valid_o  output  1  output sample present.
REQ-010 out_ready_i  input  1  downstream butterfly stage accepts the sample.
REQ-011 out_re_o, out_im_o  output  DATA_WIDTH each  signed sample, bit-reversed order.
REQ-012 out_idx_o  output  LOG2N  natural output index i (0..N-1) of the current sample.
REQ-013 out_last_o  output  1  high with the sample at i = N-1.

Function
REQ-014 Input transfer occurs when in_valid_i and in_ready_o are both high; output transfer occurs when out_valid_o and out_ready_i are both high.
REQ-015 The write counter stores transfer k (0..N-1) at bank address k; it wraps to 0 after N-1.
REQ-016 Output sample i is taken from bank address bitrev_LOG2N(i).
REQ-017 Output values are the input values sign-extended to DATA_WIDTH, with no scaling; the binary point stays at bit 15.
REQ-018 Each bank has its own state: FILL until the N-th write, then DRAIN until the output transfer with out_last_o, then FILL again.
REQ-019 out_valid_o asserts one cycle after the edge that completes a bank's N-th write (fixed latency of 1 cycle from the last input to the first output).
REQ-020 While out_valid_o is high and out_ready_i is low, out_re_o, out_im_o, out_idx_o and out_last_o hold stable.
REQ-021 Outputs are registered; the next sample is presented in the cycle after each output transfer, giving 1 sample/cycle under continuous out_ready_i.
REQ-022 in_ready_o is high iff the current write bank is in FILL; it depends on state only, never combinationally on out_ready_i.
REQ-023 When a bank's last output transfer and a write to the other bank occur in the same cycle, both take effect.
REQ-024 Banks are read in the order they were filled; no frame is dropped or reordered.

Reset
REQ-025 During rst_i, all of the following SHALL be 0: out_valid_o, out_last_o, out_idx_o, out_re_o, out_im_o, and both counters; every bank SHALL be in FILL and in_ready_o SHALL be 1 from the first cycle after reset.
REQ-026 Reset asserted mid-frame or mid-drain discards all buffered samples; bank memory contents need not be cleared.

Configuration
REQ-027 Macro BITREV_BUFFER_PINGPONG_EN defined: two banks; bank A is written while bank B drains, and roles swap at frame boundaries; with continuous traffic, in_ready_o stays high.
REQ-028 Macro absent: a single bank; in_ready_o stays low for the whole DRAIN period (at least N cycles per frame).

Structure
REQ-029 LOG2N, IN_WIDTH and DATA_WIDTH defaults, plus the bank-state encoding (FILL/DRAIN), SHALL reside in the shared FFT package.
REQ-030 Bit reversal SHALL be a pure function in the shared package; the bank memory SHALL be one sub-module, fft_sample_ram (1 write port and 1 registered read port, depth N, width 2*DATA_WIDTH), instantiated once per bank.

Verification
REQ-031 N=16, in_re=0..15, in_im=0, out_ready_i=1 -> out_re order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_last_o only on the 16th sample; first out_valid_o exactly 1 cycle after the 16th input transfer.
REQ-032 in_re=16'h8000, in_im=16'h7FFF -> out_re=21'h1F8000, out_im=21'h007FFF.
REQ-033 out_ready_i toggling 1,0,0,1,... -> no duplicated or lost samples; outputs stable during every stall; sequence identical to REQ-031.
REQ-034 Three back-to-back frames with in_valid_i=1 and out_ready_i=1: with BITREV_BUFFER_PINGPONG_EN, in_ready_o stays 1 for all 48 inputs; without it, in_ready_o=0 for 16 cycles after each frame.
REQ-035 rst_i pulsed after 7 of 16 inputs, then a full new frame sent -> only the new frame appears at the output, and it appears in bit-reversed order.
REQ-036 Ping-pong with out_ready_i=0 held while two frames are sent -> in_ready_o drops after the 32nd input; raising out_ready_i drains frame 1 and then frame 2 in order.
